// File: rtl/lane_mux_nx1_buf.sv
// N-lane to 1 byte-lane merger with a FIFO per lane and round-robin service (strict or skip-empty).
// Optional per-lane saturating drop counters appear on drop_cnt_out when LANE_MUX_DROP_CNT_EN is defined.
module lane_mux_nx1_buf #(
  parameter int DATA_W     = 8,
  parameter int N_LANES    = 2,
  parameter int DEPTH      = 4,
  parameter int SKIP_EMPTY = 0,
  parameter int LANE_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                        clk_4f,
  input  logic                        reset_L,
  input  logic [N_LANES*DATA_W-1:0]   data_in,
  input  logic [N_LANES-1:0]          valid_in,
  output logic [N_LANES-1:0]          full_out,
  output logic [DATA_W-1:0]           data_out,
  output logic                        valid_out,
  output logic [LANE_W-1:0]           lane_out
`ifdef LANE_MUX_DROP_CNT_EN
  ,
  output logic [8*N_LANES-1:0]        drop_cnt_out
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q    [N_LANES][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [N_LANES];
  logic [PTR_W-1:0]  rd_ptr_q [N_LANES];
  logic [CNT_W-1:0]  cnt_q    [N_LANES];
  logic [CNT_W-1:0]  cnt_d    [N_LANES];

  logic [N_LANES-1:0] full_s;
  logic [N_LANES-1:0] empty_s;
  logic [N_LANES-1:0] push_s;
  logic [N_LANES-1:0] pop_s;

  logic [LANE_W-1:0] rr_q, rr_d;
  logic [LANE_W-1:0] sel_s;
  logic              sel_vld_s;
  logic [DATA_W-1:0] head_s;

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [LANE_W-1:0] lane_q, lane_d;

  function automatic logic [LANE_W-1:0] rr_next(input logic [LANE_W-1:0] p);
    if (p == LANE_W'(N_LANES - 1)) begin
      return '0;
    end else begin
      return p + LANE_W'(1);
    end
  endfunction

  // Per-lane status; full is judged on pre-edge occupancy so a same-cycle pop never admits a push.
  always_comb begin
    full_s  = '0;
    empty_s = '0;
    push_s  = '0;
    for (int i = 0; i < N_LANES; i++) begin
      full_s[i]  = (cnt_q[i] == CNT_W'(DEPTH));
      empty_s[i] = (cnt_q[i] == CNT_W'(0));
      push_s[i]  = valid_in[i] & ~full_s[i];
    end
  end

  assign full_out = full_s;

  if (SKIP_EMPTY != 0) begin : g_skip
    // Cyclic search from rr_q; scanning downwards lets the nearest non-empty lane win.
    always_comb begin
      int unsigned idx_v;
      logic        hit_v;
      idx_v     = 0;
      hit_v     = 1'b0;
      sel_vld_s = 1'b0;
      sel_s     = rr_q;
      for (int k = N_LANES - 1; k >= 0; k--) begin
        idx_v     = (int'(rr_q) + k) % N_LANES;
        hit_v     = ~empty_s[idx_v];
        sel_vld_s = sel_vld_s | hit_v;
        sel_s     = hit_v ? LANE_W'(idx_v) : sel_s;
      end
      rr_d   = sel_vld_s ? rr_next(sel_s) : rr_q;
      lane_d = sel_vld_s ? sel_s : lane_q;
    end
  end else begin : g_strict
    // Strict alternation: the slot belongs to rr_q whether or not that lane has data.
    always_comb begin
      sel_s     = rr_q;
      sel_vld_s = ~empty_s[rr_q];
      rr_d      = rr_next(rr_q);
      lane_d    = rr_q;
    end
  end

  // Pop decode and next output word.
  always_comb begin
    pop_s  = '0;
    head_s = mem_q[sel_s][rd_ptr_q[sel_s]];
    if (sel_vld_s) begin
      pop_s[sel_s] = 1'b1;
      data_d       = head_s;
      valid_d      = 1'b1;
    end else begin
      data_d  = data_q;
      valid_d = 1'b0;
    end
  end

  // Occupancy next state.
  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      case ({push_s[i], pop_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Lane FIFO storage and pointers.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < N_LANES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[i][d] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (push_s[i]) begin
          mem_q[i][wr_ptr_q[i]] <= data_in[i*DATA_W +: DATA_W];
          wr_ptr_q[i]           <= wr_ptr_q[i] + PTR_W'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        end
      end
    end
  end

  // Round-robin pointer and registered merged output.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      rr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      lane_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign lane_out  = lane_q;

`ifdef LANE_MUX_DROP_CNT_EN
  logic [7:0] drop_q [N_LANES];

  // Saturating count of pushes refused because the lane was full.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < N_LANES; i++) begin
        drop_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        if (valid_in[i] && full_s[i] && (drop_q[i] != 8'hFF)) begin
          drop_q[i] <= drop_q[i] + 8'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_drop_out
    assign drop_cnt_out[g*8 +: 8] = drop_q[g];
  end
`endif

endmodule

// File: tb/tb_lane_mux_nx1_buf.sv
// Drives three configurations (N=2 strict, N=4 skip-empty, N=3 strict) from shared lane inputs
// and compares each against a queue-based reference model every cycle.
module tb_lane_mux_nx1_buf;

  localparam int NI    = 3;
  localparam int DEPTH = 4;
  localparam int NL [NI] = '{2, 4, 3};
  localparam int SK [NI] = '{0, 1, 0};

  logic        clk;
  logic        rst_n;
  logic [63:0] din_s;
  logic [7:0]  vin_s;

  logic [1:0] f0; logic [7:0] do0; logic v0; logic [0:0] l0;
  logic [3:0] f1; logic [7:0] do1; logic v1; logic [1:0] l1;
  logic [2:0] f2; logic [7:0] do2; logic v2; logic [1:0] l2;
`ifdef LANE_MUX_DROP_CNT_EN
  logic [15:0] dc0; logic [31:0] dc1; logic [23:0] dc2;
`endif

  lane_mux_nx1_buf #(.DATA_W(8), .N_LANES(2), .DEPTH(DEPTH), .SKIP_EMPTY(0)) u_dut0 (
    .clk_4f(clk), .reset_L(rst_n), .data_in(din_s[15:0]), .valid_in(vin_s[1:0]),
    .full_out(f0), .data_out(do0), .valid_out(v0), .lane_out(l0)
`ifdef LANE_MUX_DROP_CNT_EN
    , .drop_cnt_out(dc0)
`endif
  );

  lane_mux_nx1_buf #(.DATA_W(8), .N_LANES(4), .DEPTH(DEPTH), .SKIP_EMPTY(1)) u_dut1 (
    .clk_4f(clk), .reset_L(rst_n), .data_in(din_s[31:0]), .valid_in(vin_s[3:0]),
    .full_out(f1), .data_out(do1), .valid_out(v1), .lane_out(l1)
`ifdef LANE_MUX_DROP_CNT_EN
    , .drop_cnt_out(dc1)
`endif
  );

  lane_mux_nx1_buf #(.DATA_W(8), .N_LANES(3), .DEPTH(DEPTH), .SKIP_EMPTY(0)) u_dut2 (
    .clk_4f(clk), .reset_L(rst_n), .data_in(din_s[23:0]), .valid_in(vin_s[2:0]),
    .full_out(f2), .data_out(do2), .valid_out(v2), .lane_out(l2)
`ifdef LANE_MUX_DROP_CNT_EN
    , .drop_cnt_out(dc2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] o_full [NI];
  logic [7:0] o_data [NI];
  logic [7:0] o_lane [NI];
  logic       o_vld  [NI];
`ifdef LANE_MUX_DROP_CNT_EN
  logic [7:0] o_drop [NI][8];
`endif

  // Gather the three instances' outputs into uniform arrays.
  always_comb begin
    o_full[0] = 8'(f0); o_data[0] = do0; o_vld[0] = v0; o_lane[0] = 8'(l0);
    o_full[1] = 8'(f1); o_data[1] = do1; o_vld[1] = v1; o_lane[1] = 8'(l1);
    o_full[2] = 8'(f2); o_data[2] = do2; o_vld[2] = v2; o_lane[2] = 8'(l2);
`ifdef LANE_MUX_DROP_CNT_EN
    for (int i = 0; i < NI; i++) begin
      for (int l = 0; l < 8; l++) begin
        o_drop[i][l] = 8'd0;
      end
    end
    for (int l = 0; l < 2; l++) o_drop[0][l] = dc0[l*8 +: 8];
    for (int l = 0; l < 4; l++) o_drop[1][l] = dc1[l*8 +: 8];
    for (int l = 0; l < 3; l++) o_drop[2][l] = dc2[l*8 +: 8];
`endif
  end

  // Reference model: one queue per lane, a service pointer and expected outputs.
  logic [7:0] mq [NI][8][$];
  int         m_ptr  [NI];
  logic [7:0] e_data [NI];
  logic       e_vld  [NI];
  int         e_lane [NI];
  int         e_drop [NI][8];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int l = 0; l < 8; l++) begin
        mq[i][l].delete();
        e_drop[i][l] = 0;
      end
      m_ptr[i]  = 0;
      e_data[i] = 8'h00;
      e_vld[i]  = 1'b0;
      e_lane[i] = 0;
    end
  endtask

  task automatic model_step();
    int  n;
    int  sel;
    int  cand;
    bit  fullpre [8];
    for (int i = 0; i < NI; i++) begin
      n   = NL[i];
      sel = -1;
      for (int l = 0; l < 8; l++) fullpre[l] = (mq[i][l].size() == DEPTH);
      if (SK[i] == 0) begin
        if (mq[i][m_ptr[i]].size() != 0) sel = m_ptr[i];
        e_lane[i] = m_ptr[i];
        m_ptr[i]  = (m_ptr[i] + 1) % n;
      end else begin
        for (int k = 0; k < n; k++) begin
          cand = (m_ptr[i] + k) % n;
          if (sel < 0 && mq[i][cand].size() != 0) sel = cand;
        end
        if (sel >= 0) begin
          e_lane[i] = sel;
          m_ptr[i]  = (sel + 1) % n;
        end
      end
      if (sel >= 0) begin
        e_data[i] = mq[i][sel].pop_front();
        e_vld[i]  = 1'b1;
      end else begin
        e_vld[i] = 1'b0;
      end
      for (int l = 0; l < n; l++) begin
        if (vin_s[l]) begin
          if (!fullpre[l]) mq[i][l].push_back(din_s[l*8 +: 8]);
          else if (e_drop[i][l] < 255) e_drop[i][l]++;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] expf;
    for (int i = 0; i < NI; i++) begin
      expf = 8'h00;
      for (int l = 0; l < NL[i]; l++) expf[l] = (mq[i][l].size() == DEPTH);
      chk_eq($sformatf("d%0d_valid", i), o_vld[i], e_vld[i]);
      chk_eq($sformatf("d%0d_data", i), o_data[i], e_data[i]);
      chk_eq($sformatf("d%0d_lane", i), o_lane[i], e_lane[i]);
      chk_eq($sformatf("d%0d_full", i), o_full[i], expf);
      chk_eq($sformatf("d%0d_lane_range", i), (o_lane[i] < NL[i]) ? 1 : 0, 1);
`ifdef LANE_MUX_DROP_CNT_EN
      for (int l = 0; l < NL[i]; l++)
        chk_eq($sformatf("d%0d_drop%0d", i, l), o_drop[i][l], e_drop[i][l]);
`endif
    end
  endtask

  // Model the coming edge from the inputs now applied, then compare after it.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int cycles);
    vin_s = 8'h00;
    repeat (cycles) tick();
  endtask

  // Asynchronous reset during traffic; outputs must clear before any clock edge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk_eq($sformatf("d%0d_rst_valid", i), o_vld[i], 0);
      chk_eq($sformatf("d%0d_rst_data", i), o_data[i], 0);
      chk_eq($sformatf("d%0d_rst_lane", i), o_lane[i], 0);
      chk_eq($sformatf("d%0d_rst_full", i), o_full[i], 0);
    end
    model_reset();
    vin_s = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int dens;
    rst_n = 1'b0;
    vin_s = 8'h00;
    din_s = 64'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    #1 rst_n = 1'b1;

    idle(2);

    // Simultaneous push on lanes 0 and 1.
    din_s = 64'h0000_0000_0000_B1A1;
    vin_s = 8'h03;
    tick();
    idle(4);

    // Two consecutive words on lane 0 only.
    din_s = 64'h0000_0000_0000_0011;
    vin_s = 8'h01;
    tick();
    din_s = 64'h0000_0000_0000_0022;
    tick();
    idle(5);

    // Three words on lane 2 only.
    for (int w = 0; w < 3; w++) begin
      din_s = 64'(8'h30 + 8'(w)) << 16;
      vin_s = 8'h04;
      tick();
    end
    idle(6);

    // Lane 0 held valid for 6 cycles, then every lane for a burst to force drops.
    for (int w = 0; w < 6; w++) begin
      din_s = 64'(8'h40 + 8'(w));
      vin_s = 8'h01;
      tick();
    end
    for (int w = 0; w < 6; w++) begin
      din_s = {$urandom, $urandom};
      vin_s = 8'h0F;
      tick();
    end
    idle(12);

    // Buffer words everywhere, then reset mid-burst.
    for (int w = 0; w < 3; w++) begin
      din_s = {$urandom, $urandom};
      vin_s = 8'h0F;
      tick();
    end
    mid_reset();
    idle(7);

    // Randomized traffic at varying densities.
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) dens = $urandom_range(5, 95);
      din_s = {$urandom, $urandom};
      vin_s = 8'h00;
      for (int l = 0; l < 4; l++) vin_s[l] = ($urandom_range(0, 99) < dens);
      tick();
      if (c == 300) mid_reset();
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lane_mux_nx1_buf.md
Name: lane_mux_nx1_buf

Overview:
- Parametrised successor of the 2:1 byte-lane multiplexer. Merges N_LANES byte lanes into one serial lane on a single fast clock.
- Each input lane has its own small FIFO, so bursty lanes do not lose data.
- Round-robin service in one of two modes: strict alternation (the legacy behaviour) or skip-empty (work-conserving).
- Sits in the PHY transmit path between the lane-distribution logic and the serializer.

Parameters:
- DATA_W, 8, width of each lane word.
- N_LANES, 2, number of input lanes (2..8).
- DEPTH, 4, words per lane FIFO (power of 2, 2..16).
- SKIP_EMPTY, 0, 0 = strict round-robin, 1 = skip empty lanes.
- LANE_W, $clog2(N_LANES) (minimum 1), width of the lane index.

Ports:
- clk_4f  in  1  fast clock; all state updates on its rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- data_in  in  N_LANES*DATA_W  lane i word at bits [i*DATA_W +: DATA_W].
- valid_in  in  N_LANES  push request per lane.
- full_out  out  N_LANES  lane FIFO full; combinational from occupancy.
- data_out  out  DATA_W  registered merged word.
- valid_out  out  1  registered; data_out is valid.
- lane_out  out  LANE_W  registered; source lane of data_out.

Behaviour:
- Reset:
  - reset_L low clears the design asynchronously: all FIFOs empty, rr pointer = 0, data_out = 0, valid_out = 0, lane_out = 0, full_out = 0.
  - Deassertion is synchronous to clk_4f.
  - Reset asserted mid-burst discards all buffered words.
- Push:
  - At each edge, lane i writes data_in[i] when valid_in[i] = 1 and full_out[i] = 0.
  - When full_out[i] = 1, the word is dropped, even if lane i pops in the same cycle. Full is judged on pre-edge occupancy.
- Occupancy:
  - Per-lane count ranges 0..DEPTH.
  - full_out[i] = (count == DEPTH).
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
- Pop / select, evaluated on pre-edge state:
  - SKIP_EMPTY = 0:
    - Serve lane ptr. If that lane is non-empty: pop it, data_out <= head word, valid_out <= 1, lane_out <= ptr.
    - If that lane is empty: valid_out <= 0, lane_out <= ptr, data_out holds its value.
    - ptr <= (ptr == N_LANES-1) ? 0 : ptr+1 every cycle, whether or not the lane was served.
  - SKIP_EMPTY = 1:
    - sel = first non-empty lane, searching cyclically from ptr.
    - If one exists: pop it, output as above, ptr <= sel+1 (wrapping at N_LANES-1).
    - If all lanes are empty: valid_out <= 0, data_out holds, ptr holds, lane_out holds.
- Latency: a word pushed at edge k into an empty FIFO is eligible at edge k+1. The earliest valid_out is after edge k+1, in strict mode only if ptr reaches that lane then.
- Same-cycle push and pop on one lane: both occur and count is unchanged. On an empty lane the pushed word is not popped in that cycle.
- Throughput: at most one word out per cycle. Sustained input above one word per cycle in aggregate fills the FIFOs.
- Legacy equivalence: N_LANES = 2, SKIP_EMPTY = 0 gives strict lane0/lane1 alternation. valid_out is low in the slot of an idle lane.
- Non-power-of-2 N_LANES: ptr never takes values ≥ N_LANES.

Optional Feature:
- Macro: LANE_MUX_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt_out, 8 × N_LANES bits, lane i at [i*8 +: 8].
  - Each lane's count increments on every dropped push (valid_in = 1 while full_out = 1).
  - Saturates at 255 and resets to 0.
- Undefined: port and counters absent; drops are silent.

Test Plan:
- Reset + legacy alternation (N = 2, SKIP_EMPTY = 0):
  - Stimulus: push 0xA1 on lane 0 and 0xB1 on lane 1 in the same cycle.
  - Required: output sequence 0xA1/lane 0 then 0xB1/lane 1, or the reverse order depending on ptr phase. valid_out = 1 in both slots, then 0.
- Strict idle slot:
  - Stimulus: lane 1 stays empty; push 0x11, 0x22 on lane 0 in consecutive cycles.
  - Required: valid_out = 1 with 0x11, then 0 (lane 1 slot, data_out still 0x11), then 0x22.
- Skip-empty (N = 4, SKIP_EMPTY = 1):
  - Stimulus: only lane 2 holds 0x30, 0x31, 0x32.
  - Required: three consecutive valid_out = 1 cycles, lane_out = 2, values 0x30, 0x31, 0x32 in order.
- Full/drop (DEPTH = 4, strict mode, no pops reaching lane 0 in time):
  - Stimulus: hold valid_in[0] for 6 cycles.
  - Required: full_out[0] rises after the 4th accepted word; extra words are dropped; drop_cnt lane 0 = 2 (with LANE_MUX_DROP_CNT_EN); drained words are the first 4 only.
- Mid-burst reset:
  - Stimulus: assert reset_L = 0 asynchronously while 3 words are buffered.
  - Required: outputs go to 0 immediately; no buffered word appears after release.
- Wrap (N = 3, strict mode):
  - Stimulus: run idle for 7 cycles.
  - Required: lane_out sequence 0, 1, 2, 0, 1, 2, 0; never 3.
